matrix_scan_ctrl: RTL

- Scan controller for the 32x32 RGB LED matrix driven by the screen datapath.
- Walks the panel one row pair at a time: fetches pixel pairs from the screen framebuffer, shifts them out on r1/g1/b1/r2/g2/b2 with OCLK, then blanks, latches and displays the row.
- Sits between the framebuffer read port and the panel pins. It owns all panel timing and is the sole sequencer of framebuffer reads.

---
 rtl/matrix_scan_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/matrix_scan_ctrl.sv
// Row-pair scan controller for an RGB LED matrix: fetches pixel pairs from the framebuffer,
// shifts them out with OCLK, then blanks, latches and displays each row pair in turn.
module matrix_scan_ctrl #(
  parameter int unsigned COLS      = 32,
  parameter int unsigned ROW_PAIRS = 16,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned BLANK_CYC = 2,
  parameter int unsigned ON_CYC    = 64
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         enable,
  output logic [$clog2(ROW_PAIRS)+$clog2(COLS)-1:0]    pix_addr,
  input  logic [2:0]                                   pix_top,
  input  logic [2:0]                                   pix_bot,
  output logic                                         r1,
  output logic                                         g1,
  output logic                                         b1,
  output logic                                         r2,
  output logic                                         g2,
  output logic                                         b2,
  output logic                                         A,
  output logic                                         B,
  output logic                                         C,
  output logic                                         D,
  output logic                                         LAT,
  output logic                                         OEN,
  output logic                                         OCLK,
  output logic                                         frame_done
);

  localparam int unsigned RowW     = $clog2(ROW_PAIRS);
  localparam int unsigned ColW     = $clog2(COLS);
  localparam int unsigned ShiftCyc = 2 * CLK_DIV;
  localparam int unsigned CntMax0  = (ShiftCyc > BLANK_CYC) ? ShiftCyc : BLANK_CYC;
  localparam int unsigned CntMax   = (CntMax0 > ON_CYC) ? CntMax0 : ON_CYC;
  localparam int unsigned CntW     = $clog2(CntMax + 1);

  typedef enum logic [2:0] {StIdle, StShift, StBlank, StLatch, StDisplay} state_e;

  state_e              state_q, state_d;
  logic [RowW-1:0]     row_q, row_d;
  logic [ColW-1:0]     col_q, col_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [RowW+ColW-1:0] addr_q, addr_d;
  logic [5:0]          rgb_q, rgb_d;
  logic [3:0]          abcd_q, abcd_d;
  logic                lat_q, lat_d;
  logic                oen_q, oen_d;
  logic                oclk_q, oclk_d;
  logic                fd_q, fd_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rgb_d   = rgb_q;
    abcd_d  = abcd_q;
    lat_d   = 1'b0;
    oen_d   = oen_q;
    oclk_d  = 1'b0;
    fd_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StShift;
          col_d   = '0;
          cnt_d   = '0;
        end
      end
      StShift: begin
        // Framebuffer data for this column is valid in the cycle after the address.
        if (cnt_q == CntW'(1)) rgb_d = {pix_top, pix_bot};
        if (cnt_q == CntW'(ShiftCyc - 1)) begin
          cnt_d = '0;
          if (col_q == ColW'(COLS - 1)) begin
            col_d   = '0;
            state_d = StBlank;
          end else begin
            col_d = col_q + ColW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StBlank: begin
        if (cnt_q == CntW'(BLANK_CYC - 1)) begin
          cnt_d   = '0;
          state_d = StLatch;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLatch: begin
        row_d   = row_q + RowW'(1);
        cnt_d   = '0;
        state_d = StDisplay;
      end
      StDisplay: begin
        if (cnt_q == CntW'(ON_CYC - 1)) begin
          cnt_d   = '0;
          col_d   = '0;
          state_d = enable ? StShift : StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (state_d)
      StShift: begin
        addr_d = {row_d, col_d};
        oclk_d = (cnt_d >= CntW'(CLK_DIV));
        oen_d  = oen_q;
      end
      StLatch: begin
        lat_d  = 1'b1;
        oen_d  = 1'b1;
        abcd_d = 4'(row_q);
        fd_d   = (row_q == RowW'(ROW_PAIRS - 1));
      end
      StDisplay: oen_d = 1'b0;
      default:   oen_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      rgb_q   <= '0;
      abcd_q  <= '0;
      lat_q   <= 1'b0;
      oen_q   <= 1'b1;
      oclk_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rgb_q   <= rgb_d;
      abcd_q  <= abcd_d;
      lat_q   <= lat_d;
      oen_q   <= oen_d;
      oclk_q  <= oclk_d;
      fd_q    <= fd_d;
    end
  end

  assign pix_addr               = addr_q;
  assign {r1, g1, b1, r2, g2, b2} = rgb_q;
  assign {D, C, B, A}           = abcd_q;
  assign LAT                    = lat_q;
  assign OEN                    = oen_q;
  assign OCLK                   = oclk_q;
  assign frame_done             = fd_q;

endmodule
